trigger_ctrl: RTL and testbench
===============================

# trigger_ctrl

Trigger controller sitting directly downstream of the per-stage trigger comparators in the logic-analyzer trigger path. Collects the one-cycle match pulses from all stages and owns the shared trigger level that is fed back to every stage. Advances the level on non-starting matches and issues a single run pulse to the capture controller when a stage configured as a start stage matches. Arming, disarming and re-arming are commanded by the command decoder.

## Interface
- NUM_STAGES, 4, number of trigger stages feeding this block (1..8)
- LVL_W, 2, width of the level counter; maximum level is 2^LVL_W-1
- clk_i  input  1  system clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- arm_i  input  1  one-cycle pulse: arm (or re-arm) the trigger
- disarm_i  input  1  one-cycle pulse: return to idle
- stg_match_i  input  NUM_STAGES  per-stage match pulse, bit k from stage k; already qualified by that stage's level and delay
- stg_start_i  input  NUM_STAGES  static config: bit k set means a match of stage k starts capture
- level_o  output  LVL_W  current trigger level, broadcast to all stages
- armed_o  output  1  high while in ARMED
- run_o  output  1  one-cycle pulse: trigger fired, capture controller begins post-trigger capture
- fired_o  output  1  high while in FIRED

## Operation
- States: IDLE, ARMED, FIRED. Encoding free; exactly one active.
- Reset: state IDLE, level_o=0, armed_o=0, run_o=0, fired_o=0. Reset overrides all other inputs in the same cycle.
- Command priority each cycle: disarm_i > arm_i > stage matches.
- IDLE:
  - stg_match_i ignored.
  - arm_i -> ARMED, level 0.
- ARMED:
  - disarm_i -> IDLE, level 0.
  - arm_i -> stay ARMED, level forced to 0; matches in that cycle ignored.
  - Otherwise: let hit = stg_match_i, start_hit = |(hit & stg_start_i).
    - start_hit -> FIRED, run_o pulses, level unchanged.
    - else if |hit -> level +1, saturating at 2^LVL_W-1. Increments by exactly one regardless of how many bits of hit are set.
    - else hold.
- FIRED:
  - Level held. stg_match_i ignored. run_o never re-asserts.
  - arm_i -> ARMED, level 0.
  - disarm_i -> IDLE, level 0.
- armed_o = (state==ARMED). fired_o = (state==FIRED). Both are decoded from registered state; no combinational path from any input.
- run_o is a registered single-cycle pulse and is only ever set on the ARMED->FIRED transition.

## Timing
- All outputs are registered.
- Latency from input edge to output:
  - Match at edge N -> level_o or run_o/fired_o updated after edge N+1 (one cycle).
  - arm_i/disarm_i at edge N -> armed_o/fired_o/level_o updated after edge N+1.
- Stages see the new level_o one cycle after the match. A stage match asserted in the cycle immediately after a level increment is evaluated against the new state, with no masking.
- Back-to-back non-start matches on consecutive cycles increment on consecutive cycles until saturation.
- Simultaneous start and non-start matches in one cycle: start wins, no increment.
- Reset asserted mid-ARMED or mid-FIRED: outputs take reset values one edge later. A run_o pulse in progress is cut.
- Maximum one run_o pulse per arm.

## Test plan
- Reset, then arm_i; stg_start_i=4'b1000; pulse stg_match_i=0001, 0010, 0100 on separate cycles -> level_o goes 1, 2, 3. Then pulse 1000 -> run_o high exactly one cycle, fired_o=1, level_o stays 3.
- Armed, level 0; stg_match_i=0111 in one cycle with stg_start_i=0 -> level_o=1, not 3. Repeat six single pulses -> saturates at 3, no wrap.
- Armed; stg_match_i=0011 with stg_start_i=0010 -> run_o pulse, level_o stays 0.
- Idle (no arm); stg_match_i pulses on all stages -> level_o=0, run_o=0 throughout. In FIRED, further matches -> no second run_o.
- Armed at level 2; arm_i and disarm_i together -> IDLE, level 0. Separately, at level 2, arm_i with match=0001 -> level_o=0.
- ARMED at level 2; rst_i for one cycle -> next cycle all outputs 0 and state IDLE. A following arm_i works normally.

Source files
------------

// File: rtl/trigger_ctrl.sv
// Trigger controller: gathers per-stage match pulses, owns the shared trigger
// level and issues one run pulse per arm when a start stage matches.
module trigger_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int LVL_W      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  disarm_i,
  input  logic [NUM_STAGES-1:0] stg_match_i,
  input  logic [NUM_STAGES-1:0] stg_start_i,
  output logic [LVL_W-1:0]      level_o,
  output logic                  armed_o,
  output logic                  run_o,
  output logic                  fired_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] FIRED = 2'd2;

  localparam logic [LVL_W-1:0] LVL_MAX = '1;

  logic [1:0]       state, state_nxt;
  logic [LVL_W-1:0] level, level_nxt;
  logic             run, run_nxt;
  logic             any_hit, start_hit;

  assign any_hit   = |stg_match_i;
  assign start_hit = |(stg_match_i & stg_start_i);

  // Commands take priority over matches: disarm first, then arm.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    run_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (disarm_i) begin
          level_nxt = '0;
        end else if (arm_i) begin
          state_nxt = ARMED;
          level_nxt = '0;
        end
      end
      ARMED: begin
        if (disarm_i) begin
          state_nxt = IDLE;
          level_nxt = '0;
        end else if (arm_i) begin
          level_nxt = '0;
        end else if (start_hit) begin
          state_nxt = FIRED;
          run_nxt   = 1'b1;
        end else if (any_hit && level != LVL_MAX) begin
          level_nxt = level + 1'b1;
        end
      end
      FIRED: begin
        if (disarm_i) begin
          state_nxt = IDLE;
          level_nxt = '0;
        end else if (arm_i) begin
          state_nxt = ARMED;
          level_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        level_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      level <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      run   <= run_nxt;
    end
  end

  assign level_o = level;
  assign run_o   = run;
  assign armed_o = (state == ARMED);
  assign fired_o = (state == FIRED);

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed self-checking bench for trigger_ctrl; outputs are packed as
// {level, armed, run, fired} and compared against hand-computed values.
module tb_trigger_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       arm_i = 1'b0;
  logic       disarm_i = 1'b0;
  logic [3:0] stg_match_i = '0;
  logic [3:0] stg_start_i = '0;
  logic [1:0] level_o;
  logic       armed_o, run_o, fired_o;
  logic [4:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  trigger_ctrl #(.NUM_STAGES(4), .LVL_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .disarm_i(disarm_i),
    .stg_match_i(stg_match_i), .stg_start_i(stg_start_i),
    .level_o(level_o), .armed_o(armed_o), .run_o(run_o), .fired_o(fired_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {level_o, armed_o, run_o, fired_o};

  // Drive one cycle of inputs, let one edge pass, then return single-cycle
  // pulse inputs to zero; outputs are stable when the caller inspects them.
  task automatic cycle(input logic r, input logic a, input logic d, input logic [3:0] m);
    rst_i = r; arm_i = a; disarm_i = d; stg_match_i = m;
    @(posedge clk_i); #1;
    rst_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; stg_match_i = '0;
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    tests_run++;
    if (obs !== 5'b00_000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs, 5'b00_000);
    end
  endtask

  task automatic test_level_walk;
    logic [4:0] exp [5];
    logic [3:0] m   [5];
    stg_start_i = 4'b1000;
    exp = '{5'b00_100, 5'b01_100, 5'b10_100, 5'b11_100, 5'b11_011};
    m   = '{4'b0000,   4'b0001,   4'b0010,   4'b0100,   4'b1000};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, i == 0, 1'b0, m[i]);
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("[TB] FAIL level_walk[%0d]: got %b expected %b", i, obs, exp[i]);
      end
    end
    // run must drop after one cycle and never return while FIRED
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b1111);
      tests_run++;
      if (obs !== 5'b11_001) begin
        tests_failed++;
        $display("[TB] FAIL fired_hold[%0d]: got %b expected %b", i, obs, 5'b11_001);
      end
    end
  endtask

  task automatic test_multi_hit;
    logic [1:0] exp_lvl;
    stg_start_i = 4'b0000;
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0111);
    tests_run++;
    if (obs !== 5'b01_100) begin
      tests_failed++;
      $display("[TB] FAIL multi_hit_once: got %b expected %b", obs, 5'b01_100);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b0001);
      exp_lvl = (i < 2) ? 2'(i + 2) : 2'd3;
      tests_run++;
      if (obs !== {exp_lvl, 3'b100}) begin
        tests_failed++;
        $display("[TB] FAIL saturate[%0d]: got %b expected %b", i, obs, {exp_lvl, 3'b100});
      end
    end
  endtask

  task automatic test_start_priority;
    stg_start_i = 4'b0010;
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0011);
    tests_run++;
    if (obs !== 5'b00_011) begin
      tests_failed++;
      $display("[TB] FAIL start_wins: got %b expected %b", obs, 5'b00_011);
    end
    cycle(1'b0, 1'b0, 1'b0, 4'b0010);
    tests_run++;
    if (obs !== 5'b00_001) begin
      tests_failed++;
      $display("[TB] FAIL single_run: got %b expected %b", obs, 5'b00_001);
    end
  endtask

  task automatic test_idle_ignore;
    stg_start_i = 4'b1111;
    cycle(1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b1111);
      tests_run++;
      if (obs !== 5'b00_000) begin
        tests_failed++;
        $display("[TB] FAIL idle_ignore[%0d]: got %b expected %b", i, obs, 5'b00_000);
      end
    end
  endtask

  task automatic test_commands;
    stg_start_i = 4'b0000;
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    tests_run++;
    if (obs !== 5'b10_100) begin
      tests_failed++;
      $display("[TB] FAIL cmd_setup: got %b expected %b", obs, 5'b10_100);
    end
    cycle(1'b0, 1'b1, 1'b1, 4'b0000);
    tests_run++;
    if (obs !== 5'b00_000) begin
      tests_failed++;
      $display("[TB] FAIL disarm_over_arm: got %b expected %b", obs, 5'b00_000);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    cycle(1'b0, 1'b0, 1'b0, 4'b0100);
    cycle(1'b0, 1'b1, 1'b0, 4'b0001);
    tests_run++;
    if (obs !== 5'b00_100) begin
      tests_failed++;
      $display("[TB] FAIL arm_over_match: got %b expected %b", obs, 5'b00_100);
    end
  endtask

  task automatic test_reset_mid;
    stg_start_i = 4'b1000;
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    tests_run++;
    if (obs !== 5'b00_000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_armed: got %b expected %b", obs, 5'b00_000);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001);
    tests_run++;
    if (obs !== 5'b01_100) begin
      tests_failed++;
      $display("[TB] FAIL rearm_after_reset: got %b expected %b", obs, 5'b01_100);
    end
    // reset coinciding with a start match must suppress the run pulse
    cycle(1'b1, 1'b0, 1'b0, 4'b1000);
    tests_run++;
    if (obs !== 5'b00_000) begin
      tests_failed++;
      $display("[TB] FAIL reset_beats_start: got %b expected %b", obs, 5'b00_000);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(1'b0, 1'b0, 1'b0, 4'b1000);
    cycle(1'b1, 1'b0, 1'b0, 4'b0000);
    tests_run++;
    if (obs !== 5'b00_000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_fired: got %b expected %b", obs, 5'b00_000);
    end
  endtask

  initial begin
    @(posedge clk_i); #1;
    test_reset();
    test_level_walk();
    test_multi_hit();
    test_start_priority();
    test_idle_ignore();
    test_commands();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
